// File: rtl/key_lock_if.sv
// Keypad-side and status signals of the key lock controller.
// The master drives key strobes and observes status; the slave is the controller.
interface key_lock_if;
  logic        key_en;
  logic [3:0]  key_num;
  logic [15:0] entry_digits;
  logic [2:0]  entry_cnt;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  fail_cnt;
  logic [2:0]  state;

  // key_en is a single-cycle strobe with no back-pressure; key_num is meaningful only while key_en=1.
  modport master (
    output key_en, key_num,
    input  entry_digits, entry_cnt, unlocked, alarm, fail_cnt, state
  );

  modport slave (
    input  key_en, key_num,
    output entry_digits, entry_cnt, unlocked, alarm, fail_cnt, state
  );
endinterface

// File: rtl/key_lock_ctrl.sv
// Four-digit keypad lock with timed relock, failed-attempt lockout and optional code programming.
// Define KEY_LOCK_PROGRAM_EN to build the PROGRAM state and the writable code register.
module key_lock_ctrl #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned UNLOCK_CYCLES  = 300000000,
    parameter int unsigned LOCKOUT_CYCLES = 1000000000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic       clk,
    input  logic       reset,
    key_lock_if.slave  kif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_PROGRAM  = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    localparam logic [31:0] UNLOCK_LOAD  = UNLOCK_CYCLES - 1;
    localparam logic [31:0] LOCKOUT_LOAD = LOCKOUT_CYCLES - 1;
    localparam logic [1:0]  FAIL_LIMIT   = 2'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d;
    logic [31:0] timer_q, timer_d;
    logic        unlocked_q, unlocked_d;
    logic        alarm_q, alarm_d;
    logic [15:0] code_q;
    logic        is_digit, is_star, is_hash;

`ifdef KEY_LOCK_PROGRAM_EN
    logic [15:0] code_d;
    logic        is_a;
    assign is_a = kif.key_en && (kif.key_num == 4'hA);
`else
    assign code_q = DEFAULT_CODE;
`endif

    assign is_digit = kif.key_en && (kif.key_num <= 4'd9);
    assign is_star  = kif.key_en && (kif.key_num == 4'hE);
    assign is_hash  = kif.key_en && (kif.key_num == 4'hF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            digits_q   <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
`ifdef KEY_LOCK_PROGRAM_EN
            code_q     <= DEFAULT_CODE;
`endif
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
`ifdef KEY_LOCK_PROGRAM_EN
            code_q     <= code_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
`ifdef KEY_LOCK_PROGRAM_EN
        code_d   = code_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (is_digit) begin
                    digits_d = {digits_q[11:0], kif.key_num};
                    cnt_d    = cnt_q + 3'd1;
                    state_d  = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (is_digit) begin
                    if (cnt_q < 3'd4) begin
                        digits_d = {digits_q[11:0], kif.key_num};
                        cnt_d    = cnt_q + 3'd1;
                    end
                end else if (is_star) begin
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else if (is_hash) begin
                    digits_d = '0;
                    cnt_d    = '0;
                    if (cnt_q == 3'd4 && digits_q == code_q) begin
                        state_d = S_UNLOCKED;
                        fail_d  = '0;
                        timer_d = UNLOCK_LOAD;
                    end else begin
                        fail_d = fail_q + 2'd1;
                        if (fail_q + 2'd1 == FAIL_LIMIT) begin
                            state_d = S_LOCKOUT;
                            timer_d = LOCKOUT_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_UNLOCKED: begin
                // Expiry takes priority over any key arriving in the same cycle.
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 32'd1;
                    if (is_star || is_hash) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                    end
`ifdef KEY_LOCK_PROGRAM_EN
                    else if (is_a) begin
                        state_d  = S_PROGRAM;
                        digits_d = '0;
                        cnt_d    = '0;
                    end
`endif
                end
            end
`ifdef KEY_LOCK_PROGRAM_EN
            S_PROGRAM: begin
                // Timer holds its value while a new code is being entered.
                if (is_digit) begin
                    if (cnt_q < 3'd4) begin
                        digits_d = {digits_q[11:0], kif.key_num};
                        cnt_d    = cnt_q + 3'd1;
                    end
                end else if (is_hash && cnt_q == 3'd4) begin
                    code_d   = digits_q;
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else if (is_star) begin
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
`endif
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unlocked_d = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
        alarm_d    = (state_d == S_LOCKOUT);
    end

    assign kif.state        = state_q;
    assign kif.entry_digits = digits_q;
    assign kif.entry_cnt    = cnt_q;
    assign kif.fail_cnt     = fail_q;
    assign kif.unlocked     = unlocked_q;
    assign kif.alarm        = alarm_q;

endmodule

// File: tb/tb_key_lock_ctrl.sv
// Self-checking bench for key_lock_ctrl: directed vector table, hand sequences for timed states,
// and randomized keys checked against a queue-based reference model.
module tb_key_lock_ctrl;
  localparam int UNLOCK_N  = 20;
  localparam int LOCKOUT_N = 50;
  localparam int FAIL_N    = 3;
`ifdef KEY_LOCK_PROGRAM_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  key_lock_if kif();

  key_lock_ctrl #(
    .DEFAULT_CODE  (16'h1234),
    .UNLOCK_CYCLES (UNLOCK_N),
    .LOCKOUT_CYCLES(LOCKOUT_N),
    .MAX_FAIL      (FAIL_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kif  (kif)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_mode;     // 0 idle, 1 entry, 2 unlocked, 3 program, 4 lockout
  int m_q[$];     // entered digits, oldest first
  int m_fail;
  int m_left;     // cycles still to be spent in the current timed state
  int m_code;

  function automatic int m_val();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return v;
  endfunction

  task automatic model_step(input bit rst, input bit en, input int num);
    bit ok;
    if (rst) begin
      m_mode = 0; m_q.delete(); m_fail = 0; m_left = 0; m_code = 'h1234;
      return;
    end
    case (m_mode)
      0: if (en && num <= 9) begin m_q.push_back(num); m_mode = 1; end
      1: if (en) begin
        if (num <= 9) begin
          if (m_q.size() < 4) m_q.push_back(num);
        end else if (num == 14) begin
          m_q.delete(); m_mode = 0;
        end else if (num == 15) begin
          ok = (m_q.size() == 4) && (m_val() == m_code);
          m_q.delete();
          if (ok) begin
            m_mode = 2; m_fail = 0; m_left = UNLOCK_N;
          end else begin
            m_fail++;
            if (m_fail == FAIL_N) begin m_mode = 4; m_left = LOCKOUT_N; end
            else m_mode = 0;
          end
        end
      end
      2: begin
        if (m_left == 1) m_mode = 0;
        else begin
          m_left--;
          if (en && (num == 14 || num == 15)) m_mode = 0;
          else if (PROG && en && num == 10) begin m_mode = 3; m_q.delete(); end
        end
      end
      3: if (en) begin
        if (num <= 9) begin
          if (m_q.size() < 4) m_q.push_back(num);
        end else if (num == 15 && m_q.size() == 4) begin
          m_code = m_val(); m_q.delete(); m_mode = 0;
        end else if (num == 14) begin
          m_q.delete(); m_mode = 0;
        end
      end
      4: begin
        if (m_left == 1) begin m_mode = 0; m_fail = 0; end
        else m_left--;
      end
      default: m_mode = 0;
    endcase
  endtask

  // ---------------- driver / checker ----------------
  task automatic tick(input bit rst, input bit en, input logic [3:0] num);
    @(negedge clk);
    reset = rst;
    kif.key_en = en;
    kif.key_num = num;
    @(posedge clk);
    #1;
    model_step(rst, en, int'(num));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_state"}, 32'(kif.state), 32'(m_mode));
    chk({tag, "_digits"}, 32'(kif.entry_digits), 32'(m_val()));
    chk({tag, "_cnt"}, 32'(kif.entry_cnt), 32'(m_q.size()));
    chk({tag, "_fail"}, 32'(kif.fail_cnt), 32'(m_fail));
    chk({tag, "_unlocked"}, 32'(kif.unlocked), 32'(m_mode == 2 || m_mode == 3));
    chk({tag, "_alarm"}, 32'(kif.alarm), 32'(m_mode == 4));
  endtask

  task automatic enter4(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) tick(1'b0, 1'b1, code[i*4 +: 4]);
    tick(1'b0, 1'b1, 4'hF);
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  num;
    logic [2:0]  st;
    logic [15:0] dig;
    logic [2:0]  cnt;
    logic [1:0]  fl;
    logic        unl;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [3:0] num;
    bit en, rst;
    int sel;

    kif.key_en = 1'b0;
    kif.key_num = 4'h0;

    // reset state
    tick(1'b1, 1'b0, 4'h0);
    chk("reset_state", 32'(kif.state), 0);
    chk("reset_digits", 32'(kif.entry_digits), 0);
    chk("reset_cnt", 32'(kif.entry_cnt), 0);
    chk("reset_unlocked", 32'(kif.unlocked), 0);
    chk("reset_alarm", 32'(kif.alarm), 0);

    // overflow digit, clear, ignored keys, then the correct code
    vt.push_back('{1'b1, 4'h1, 3'd1, 16'h0001, 3'd1, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h2, 3'd1, 16'h0012, 3'd2, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h3, 3'd1, 16'h0123, 3'd3, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h4, 3'd1, 16'h1234, 3'd4, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h5, 3'd1, 16'h1234, 3'd4, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hE, 3'd0, 16'h0000, 3'd0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hB, 3'd0, 16'h0000, 3'd0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hF, 3'd0, 16'h0000, 3'd0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hA, 3'd0, 16'h0000, 3'd0, 2'd0, 1'b0});
    vt.push_back('{1'b0, 4'h7, 3'd0, 16'h0000, 3'd0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h1, 3'd1, 16'h0001, 3'd1, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hC, 3'd1, 16'h0001, 3'd1, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hE, 3'd0, 16'h0000, 3'd0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h1, 3'd1, 16'h0001, 3'd1, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h2, 3'd1, 16'h0012, 3'd2, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h3, 3'd1, 16'h0123, 3'd3, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'h4, 3'd1, 16'h1234, 3'd4, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hF, 3'd2, 16'h0000, 3'd0, 2'd0, 1'b1});
    for (int i = 0; i < vt.size(); i++) begin
      tick(1'b0, vt[i].en, vt[i].num);
      chk($sformatf("vec%0d_state", i), 32'(kif.state), 32'(vt[i].st));
      chk($sformatf("vec%0d_digits", i), 32'(kif.entry_digits), 32'(vt[i].dig));
      chk($sformatf("vec%0d_cnt", i), 32'(kif.entry_cnt), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_fail", i), 32'(kif.fail_cnt), 32'(vt[i].fl));
      chk($sformatf("vec%0d_unlocked", i), 32'(kif.unlocked), 32'(vt[i].unl));
    end

    // unlocked lasts exactly UNLOCK_N cycles; a key on the expiry edge is dropped
    for (int k = 1; k < UNLOCK_N; k++) begin
      tick(1'b0, 1'b0, 4'h0);
      chk($sformatf("unlock_hold%0d", k), 32'({kif.state, kif.unlocked}), 32'({3'd2, 1'b1}));
    end
    tick(1'b0, 1'b1, 4'h1);
    chk("unlock_expire_state", 32'(kif.state), 0);
    chk("unlock_expire_unlocked", 32'(kif.unlocked), 0);
    chk("unlock_expire_cnt", 32'(kif.entry_cnt), 0);

    // three wrong codes lead to lockout
    for (int r = 0; r < 3; r++) begin
      enter4(16'h5555);
      chk($sformatf("fail_round%0d_cnt", r), 32'(kif.fail_cnt), 32'(r + 1));
      chk($sformatf("fail_round%0d_state", r), 32'(kif.state), (r < 2) ? 0 : 4);
    end
    chk("lockout_alarm", 32'(kif.alarm), 1);
    for (int k = 1; k < LOCKOUT_N; k++) begin
      tick(1'b0, 1'b1, (k % 5 == 4) ? 4'hF : 4'(k % 10));
      chk($sformatf("lockout_hold%0d", k), 32'({kif.state, kif.alarm, kif.entry_cnt}),
          32'({3'd4, 1'b1, 3'd0}));
    end
    tick(1'b0, 1'b1, 4'h1);
    chk("lockout_exit_state", 32'(kif.state), 0);
    chk("lockout_exit_fail", 32'(kif.fail_cnt), 0);
    chk("lockout_exit_alarm", 32'(kif.alarm), 0);
    chk("lockout_exit_cnt", 32'(kif.entry_cnt), 0);

    // short entry counts as a failure
    tick(1'b0, 1'b1, 4'h1);
    tick(1'b0, 1'b1, 4'hF);
    chk("short_entry_fail", 32'(kif.fail_cnt), 1);
    chk("short_entry_state", 32'(kif.state), 0);

    // reset in UNLOCKED with '#' pressed on the same edge
    enter4(16'h1234);
    chk("pre_reset_state", 32'(kif.state), 2);
    tick(1'b1, 1'b1, 4'hF);
    chk("rst_unl_state", 32'(kif.state), 0);
    chk("rst_unl_digits", 32'(kif.entry_digits), 0);
    chk("rst_unl_cnt", 32'(kif.entry_cnt), 0);
    chk("rst_unl_fail", 32'(kif.fail_cnt), 0);
    chk("rst_unl_unlocked", 32'(kif.unlocked), 0);
    chk("rst_unl_alarm", 32'(kif.alarm), 0);

`ifdef KEY_LOCK_PROGRAM_EN
    enter4(16'h1234);
    tick(1'b0, 1'b1, 4'hA);
    chk("prog_enter_state", 32'(kif.state), 3);
    chk("prog_enter_unlocked", 32'(kif.unlocked), 1);
    tick(1'b0, 1'b1, 4'h9);
    tick(1'b0, 1'b1, 4'h8);
    tick(1'b0, 1'b1, 4'hF);
    chk("prog_short_hash_state", 32'(kif.state), 3);
    chk("prog_short_hash_cnt", 32'(kif.entry_cnt), 2);
    tick(1'b0, 1'b1, 4'h7);
    tick(1'b0, 1'b1, 4'h6);
    chk("prog_digits", 32'(kif.entry_digits), 32'h9876);
    tick(1'b0, 1'b1, 4'hF);
    chk("prog_write_state", 32'(kif.state), 0);
    chk("prog_write_cnt", 32'(kif.entry_cnt), 0);
    enter4(16'h1234);
    chk("old_code_fail", 32'(kif.fail_cnt), 1);
    chk("old_code_state", 32'(kif.state), 0);
    enter4(16'h9876);
    chk("new_code_state", 32'(kif.state), 2);
    tick(1'b1, 1'b0, 4'h0);
    enter4(16'h1234);
    chk("code_after_reset_state", 32'(kif.state), 2);
    tick(1'b1, 1'b0, 4'h0);
`endif

    // randomized keys against the reference model
    tick(1'b1, 1'b0, 4'h0);
    check_model("rnd_start");
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 699) == 0);
      en = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 5)
        num = (m_q.size() < 4) ? 4'((m_code >> (4 * (3 - m_q.size()))) & 15) : 4'hF;
      else if (sel == 5) num = 4'hE;
      else if (sel == 6) num = 4'hF;
      else if (sel == 7) num = 4'hA;
      else num = 4'($urandom_range(0, 15));
      tick(rst, en, num);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_lock_ctrl.md
KEY_LOCK_CTRL -- requirements
Module: key_lock_ctrl

Interface
REQ-001 Parameter DEFAULT_CODE, 16'h1234, four BCD digits loaded as the unlock code at reset (first-entered digit in [15:12]).
REQ-002 Parameter UNLOCK_CYCLES, 300000000, clock cycles spent in UNLOCKED before the automatic relock.
REQ-003 Parameter LOCKOUT_CYCLES, 1000000000, clock cycles spent in LOCKOUT.
REQ-004 Parameter MAX_FAIL, 3, number of consecutive failed attempts that triggers LOCKOUT (range 1-3).
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key_en  input  1  one-cycle key-press strobe from the keypad scanner.
REQ-008 key_num  input  4  key code: 0-9 digits, A-D letters, E '*', F '#'; valid only when key_en=1.
REQ-009 entry_digits  output  16  entered digits for the 7-segment display, newest digit in [3:0].
REQ-010 entry_cnt  output  3  number of digits held (0-4).
REQ-011 unlocked  output  1  high in UNLOCKED and PROGRAM.
REQ-012 alarm  output  1  high in LOCKOUT.
REQ-013 fail_cnt  output  2  consecutive failed attempts.
REQ-014 state  output  3  encoding: IDLE=0, ENTRY=1, UNLOCKED=2, PROGRAM=3, LOCKOUT=4.

Function
REQ-015 All outputs are registered; a key with key_en=1 in cycle N is reflected on the outputs after edge N+1. key_num is ignored when key_en=0.
REQ-016 Digit shift: entry_digits <= {entry_digits[11:0], key_num}; entry_cnt increments. When entry_cnt=4, further digits are ignored.
REQ-017 IDLE: a digit key shifts the digit in and moves to ENTRY. All other keys are ignored.
REQ-018 ENTRY: a digit key shifts per REQ-016. '*' clears the entry and returns to IDLE; fail_cnt is unchanged.
REQ-019 ENTRY, '#' with entry_cnt=4 and entry_digits==code: go to UNLOCKED, clear fail_cnt, load the timer with UNLOCK_CYCLES-1.
REQ-020 ENTRY, '#' in any other case (fewer than 4 digits, or mismatch): fail_cnt increments.
- If the new count equals MAX_FAIL, go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1.
- Otherwise return to IDLE.
REQ-021 Any exit from ENTRY clears entry_digits and entry_cnt.
REQ-022 UNLOCKED: the timer decrements every cycle. At timer=0 the block goes to IDLE, and any key in that same cycle is ignored (expiry wins).
REQ-023 UNLOCKED: '*' or '#' relocks immediately (go to IDLE). Letters A-D and digits are ignored, except as given in REQ-029.
REQ-024 LOCKOUT: all keys are ignored and the timer decrements. At timer=0 the block goes to IDLE and clears fail_cnt.
REQ-025 The timer is 32 bits wide, so each timed state lasts exactly its CYCLES value.
REQ-026 B, C and D keys are ignored in every state.

Reset
REQ-027 Reset applies on the clock edge where reset=1 and overrides any key in that cycle. It returns: state=IDLE; entry_digits=0; entry_cnt=0; fail_cnt=0; unlocked=0; alarm=0; timer=0; code=DEFAULT_CODE.
REQ-028 Reset in any state, including PROGRAM and LOCKOUT, discards a programmed code and any pending lockout.

Configuration
REQ-029 With macro KEY_LOCK_PROGRAM_EN defined, key 'A' in UNLOCKED moves to PROGRAM and clears the entry. In PROGRAM:
- unlocked=1 and the timer is frozen;
- digits shift in per REQ-016;
- '#' with entry_cnt=4 writes code <= entry_digits, clears the entry and goes to IDLE;
- '#' with entry_cnt<4 is ignored;
- '*' aborts to IDLE with the code unchanged and the entry cleared.
REQ-030 Without KEY_LOCK_PROGRAM_EN, the PROGRAM state and code register are not built: the code is the constant DEFAULT_CODE and 'A' is ignored in every state.

Verification (UNLOCK_CYCLES=20, LOCKOUT_CYCLES=50, MAX_FAIL=3)
REQ-031 Bench SHALL cover: reset, then keys 1,2,3,4,'#' -> entry_digits steps 0001, 0012, 0123, 1234; after '#', state=2, unlocked=1 for exactly 20 cycles, then state=0.
REQ-032 Bench SHALL cover: keys 5,5,5,5,'#' three times -> fail_cnt 1, 2, then state=4 with alarm=1 for 50 cycles; keys pressed during LOCKOUT have no effect; then state=0 and fail_cnt=0.
REQ-033 Bench SHALL cover: keys 1,2,3,4,5 -> entry_digits=1234, entry_cnt=4 (5 ignored); then '*' -> state=0, entry_cnt=0, fail_cnt=0.
REQ-034 Bench SHALL cover, with KEY_LOCK_PROGRAM_EN: unlock, then 'A',9,8,7,6,'#' -> state=0. Keys 1,2,3,4,'#' then fails (fail_cnt=1) and 9,8,7,6,'#' unlocks. Reset, then 1,2,3,4,'#' unlocks.
REQ-035 Bench SHALL cover: reset asserted in UNLOCKED with key_en=1 and key_num=F -> all outputs take their reset values on that edge.
